// File: rtl/cpu_pkg.sv
// Shared CPU types: opcode encoding, fetch sequencer states and default widths.
package cpu_pkg;

    localparam int PC_W_DEF    = 10;
    localparam int INSTR_W_DEF = 9;

    typedef enum logic [2:0] {
        OP_SB  = 3'b000,
        OP_LB  = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_CPY = 3'b101,
        OP_SL  = 3'b110,
        OP_BNE = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC select: branch target when taken, otherwise sequential increment (wraps).
module pc_next
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic            taken,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] next_pc
);

    assign next_pc = taken ? target : pc + PC_W'(1);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: owns the PC, reads instruction memory via req/ack,
// hands each word to the core via valid/ready, applies bne redirects and halts at HALT_PC.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int              PC_W    = PC_W_DEF,
    parameter int              INSTR_W = INSTR_W_DEF,
    parameter logic [PC_W-1:0] HALT_PC = '1,
    parameter int              CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Start,
    output logic               ImemReq,
    output logic [PC_W-1:0]    ImemAddr,
    input  logic               ImemAck,
    input  logic [INSTR_W-1:0] ImemData,
    output logic               InstrValid,
    output logic [INSTR_W-1:0] Instr,
    output logic [2:0]         Opcode,
    output logic [PC_W-1:0]    InstrPC,
    input  logic               InstrReady,
    input  logic               BranchTaken,
    input  logic [PC_W-1:0]    BranchTarget,
    output logic               Halt,
    output logic [CNT_W-1:0]   RetiredCnt
);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt, pc_seq;
    logic            load_instr;
    logic            restart;
    logic            accept;
    opcode_t         op;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    pc_next #(.PC_W(PC_W)) u_pc_next (
        .pc      (pc),
        .taken   (BranchTaken),
        .target  (BranchTarget),
        .next_pc (pc_seq)
    );

    assign accept   = (state == ISSUE) && InstrReady;
    assign ImemAddr = pc;
    assign op       = opcode_t'(Instr[INSTR_W-1 -: 3]);
    assign Opcode   = op;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        load_instr = 1'b0;
        restart    = 1'b0;
        ImemReq    = 1'b0;
        InstrValid = 1'b0;
        Halt       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    restart   = 1'b1;
                    pc_nxt    = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                ImemReq = 1'b1;
                if (ImemAck) begin
                    load_instr = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                InstrValid = 1'b1;
                if (InstrReady) begin
                    pc_nxt = pc_seq;
                    // a taken branch on the last instruction keeps the program running
                    state_nxt = (InstrPC == HALT_PC && !BranchTaken) ? HALT : FETCH;
                end
            end
            HALT: begin
                Halt = 1'b1;
                if (Start) begin
                    restart   = 1'b1;
                    pc_nxt    = '0;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            pc         <= '0;
            Instr      <= '0;
            InstrPC    <= '0;
            RetiredCnt <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (load_instr) begin
                Instr   <= ImemData;
                InstrPC <= pc;
            end
            if (restart)
                RetiredCnt <= '0;
            else if (accept)
                RetiredCnt <= sat_inc(RetiredCnt);
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: table of fetch/issue transactions plus reset/halt sequences.
module tb_inst_fetch;

    logic       CLK, Reset, Start;
    logic       ImemReq, ImemAck;
    logic [9:0] ImemAddr;
    logic [8:0] ImemData;
    logic       InstrValid, InstrReady, BranchTaken, Halt;
    logic [8:0] Instr;
    logic [2:0] Opcode;
    logic [9:0] InstrPC, BranchTarget;
    logic [15:0] RetiredCnt;

    int checks = 0;
    int errors = 0;

    inst_fetch #(.PC_W(10), .INSTR_W(9), .HALT_PC(10'd2), .CNT_W(16)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Start        (Start),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemAck      (ImemAck),
        .ImemData     (ImemData),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .Opcode       (Opcode),
        .InstrPC      (InstrPC),
        .InstrReady   (InstrReady),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Halt         (Halt),
        .RetiredCnt   (RetiredCnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0] addr;
        logic [8:0] data;
        int         ack_wait;
        int         rdy_wait;
        logic       taken;
        logic [9:0] target;
        logic       halt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        chk("start_req", ImemReq, 1);
        chk("start_addr", ImemAddr, 0);
        chk("start_halt_clr", Halt, 0);
        chk("start_cnt_clr", RetiredCnt, 0);
    endtask

    // Entered at a negedge where the fetch for v.addr should already be requested.
    task automatic run_entry(input vec_t v);
        chk("req", ImemReq, 1);
        chk("addr", ImemAddr, v.addr);
        for (int k = 0; k < v.ack_wait; k++) begin
            Start = (k == 0);
            @(negedge CLK);
            Start = 1'b0;
            chk("wait_req", ImemReq, 1);
            chk("wait_addr", ImemAddr, v.addr);
            chk("wait_valid", InstrValid, 0);
        end
        ImemAck  = 1'b1;
        ImemData = v.data;
        @(negedge CLK);
        ImemAck = 1'b0;
        chk("valid", InstrValid, 1);
        chk("req_off", ImemReq, 0);
        chk("instr", Instr, v.data);
        chk("instr_pc", InstrPC, v.addr);
        chk("opcode", Opcode, v.data[8:6]);
        for (int k = 0; k < v.rdy_wait; k++) begin
            BranchTaken  = 1'b1;
            BranchTarget = 10'h155;
            ImemAck      = 1'b1;
            ImemData     = 9'h1FF;
            @(negedge CLK);
            chk("stall_valid", InstrValid, 1);
            chk("stall_instr", Instr, v.data);
            chk("stall_pc", InstrPC, v.addr);
            chk("stall_req", ImemReq, 0);
        end
        ImemAck      = 1'b0;
        InstrReady   = 1'b1;
        BranchTaken  = v.taken;
        BranchTarget = v.target;
        @(negedge CLK);
        InstrReady  = 1'b0;
        BranchTaken = 1'b0;
        chk("post_valid", InstrValid, 0);
        if (v.halt) begin
            chk("halt", Halt, 1);
            chk("halt_req", ImemReq, 0);
        end else begin
            chk("next_req", ImemReq, 1);
            chk("no_halt", Halt, 0);
        end
    endtask

    initial begin
        tbl[0]  = '{10'h000, 9'h081, 0, 0, 1'b0, 10'h000, 1'b0};
        tbl[1]  = '{10'h001, 9'h082, 0, 0, 1'b0, 10'h000, 1'b0};
        tbl[2]  = '{10'h002, 9'h083, 0, 0, 1'b0, 10'h000, 1'b1};
        tbl[3]  = '{10'h000, 9'h104, 0, 0, 1'b0, 10'h000, 1'b0};
        tbl[4]  = '{10'h001, 9'h145, 0, 0, 1'b0, 10'h000, 1'b0};
        tbl[5]  = '{10'h002, 9'h1C6, 0, 0, 1'b1, 10'h005, 1'b0};
        tbl[6]  = '{10'h005, 9'h187, 3, 4, 1'b0, 10'h000, 1'b0};
        tbl[7]  = '{10'h006, 9'h008, 0, 0, 1'b0, 10'h000, 1'b0};
        tbl[8]  = '{10'h007, 9'h1C3, 0, 0, 1'b1, 10'h003, 1'b0};
        tbl[9]  = '{10'h003, 9'h049, 0, 0, 1'b1, 10'h3FF, 1'b0};
        tbl[10] = '{10'h3FF, 9'h08A, 0, 2, 1'b0, 10'h000, 1'b0};
        tbl[11] = '{10'h000, 9'h08B, 0, 0, 1'b0, 10'h000, 1'b0};

        Reset = 1'b1; Start = 1'b0; ImemAck = 1'b0; ImemData = '0;
        InstrReady = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        #1;
        chk("rst_req", ImemReq, 0);
        chk("rst_valid", InstrValid, 0);
        chk("rst_halt", Halt, 0);
        chk("rst_cnt", RetiredCnt, 0);
        chk("rst_addr", ImemAddr, 0);
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("idle_req", ImemReq, 0);

        // three ADDs ending at HALT_PC
        pulse_start();
        for (int i = 0; i < 3; i++) run_entry(tbl[i]);
        chk("run1_cnt", RetiredCnt, 3);
        @(negedge CLK);
        chk("halt_sticky", Halt, 1);
        chk("halt_noreq", ImemReq, 0);

        // restart from HALT; branches, stalls and PC wrap
        pulse_start();
        for (int i = 3; i < 12; i++) run_entry(tbl[i]);
        chk("run2_cnt", RetiredCnt, 9);
        chk("run2_addr", ImemAddr, 1);

        // asynchronous reset while an instruction is being issued and accepted
        ImemAck  = 1'b1;
        ImemData = 9'h0D5;
        @(negedge CLK);
        ImemAck = 1'b0;
        chk("pre_rst_valid", InstrValid, 1);
        InstrReady = 1'b1;
        Reset      = 1'b1;
        #1;
        chk("mid_rst_valid", InstrValid, 0);
        chk("mid_rst_instr", Instr, 0);
        chk("mid_rst_pc", InstrPC, 0);
        chk("mid_rst_addr", ImemAddr, 0);
        chk("mid_rst_cnt", RetiredCnt, 0);
        chk("mid_rst_opcode", Opcode, 0);
        @(negedge CLK);
        Reset      = 1'b0;
        InstrReady = 1'b0;
        @(negedge CLK);
        chk("post_rst_req", ImemReq, 0);
        pulse_start();
        run_entry(tbl[3]);
        chk("restart_cnt", RetiredCnt, 1);
        chk("restart_addr", ImemAddr, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
